// File: rtl/xor_scrambler_pkg.sv
// Shared types and defaults for the LFSR-keyed XOR stream scrambler.
// Mode encoding matches the 2-bit mode port.
package xor_scrambler_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_MSCR = 2'b01,
        MODE_MDSC = 2'b10,
        MODE_BYP  = 2'b11
    } mode_t;

    localparam int          DEF_LFSR_W = 7;
    localparam logic [31:0] DEF_TAPS   = 32'h0000_0060;
    localparam logic [31:0] DEF_SEED   = 32'h0000_007F;

    // An all-zero seed would lock the additive keystream at zero.
    function automatic logic [31:0] fix_seed(
        input logic [31:0] val,
        input logic [31:0] dflt
    );
        return (val == '0) ? dflt : val;
    endfunction

endpackage

// File: rtl/xor_lfsr_step.sv
// Combinational word step: unrolls the LFSR over DATA_W bits, LSB first.
// Bypass passes data through and leaves the state untouched.
module xor_lfsr_step
    import xor_scrambler_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 7,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS)
) (
    input  logic [LFSR_W-1:0] state,
    input  logic [DATA_W-1:0] data,
    input  mode_t             mode,
    output logic [LFSR_W-1:0] next_state,
    output logic [DATA_W-1:0] out_data
);

    logic [LFSR_W-1:0] s;
    logic              k;
    logic              fb;

    always_comb begin
        s        = state;
        k        = 1'b0;
        fb       = 1'b0;
        out_data = data;
        if (mode != MODE_BYP) begin
            for (int i = 0; i < DATA_W; i++) begin
                k           = ^(s & TAPS);
                out_data[i] = data[i] ^ k;
                unique case (1'b1)
                    (mode == MODE_MSCR): fb = out_data[i];
                    (mode == MODE_MDSC): fb = data[i];
                    default:             fb = k;
                endcase
                s = {s[LFSR_W-2:0], fb};
            end
        end
        next_state = s;
    end

endmodule

// File: rtl/xor_scrambler.sv
// Registered valid/ready XOR scrambler: state register, 1-deep output
// stage and accepted-word counter around the combinational word step.
module xor_scrambler
    import xor_scrambler_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED),
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  word_cnt
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] base_state;
    logic [LFSR_W-1:0] step_state;
    logic [DATA_W-1:0] step_data;
    logic              accept;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // A same-cycle seed load feeds the word step directly.
    always_comb begin
        base_state = state_q;
        if (seed_load) begin
            base_state = (seed_val == '0) ? SEED : seed_val;
        end
    end

    xor_lfsr_step #(
        .DATA_W (DATA_W),
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_step (
        .state      (base_state),
        .data       (s_data),
        .mode       (mode_t'(mode)),
        .next_state (step_state),
        .out_data   (step_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else if (accept) begin
            state_q <= step_state;
        end else begin
            state_q <= base_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= step_data;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (seed_load) begin
            word_cnt <= accept ? CNT_W'(1) : '0;
        end else if (accept) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

endmodule
